// File: rtl/pixel_normalizer.sv
// Per-frame min/max calibration with a serial restoring divider that produces the
// gain; pixels are offset-subtracted, scaled and saturated to 8 bits in a 2-stage pipeline.
module pixel_normalizer #(
  parameter  int MAX_ADDR = 767,
  localparam int ADDRW    = $clog2(MAX_ADDR + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [ADDRW-1:0] i_addr,
  input  logic [15:0]      i_data,
  output logic             o_wr_valid,
  output logic [ADDRW-1:0] o_wr_addr,
  output logic [7:0]       o_wr_data,
  output logic             o_busy,
  output logic             o_cal_valid
);

  localparam logic [15:0] DIVIDEND = 16'hFF00;

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  state_t      state, state_nxt;
  logic        frame_end;
  logic        load_en;
  logic [15:0] run_min, run_max;
  logic [15:0] stat_min, stat_max;
  logic [15:0] div_min, div_den;
  logic [15:0] dvd, rem, quo;
  logic [16:0] trial;
  logic [3:0]  iter;
  logic [15:0] act_min, act_scale;

  logic             s1_valid;
  logic [ADDRW-1:0] s1_addr;
  logic [15:0]      s1_diff;
  logic [15:0]      s1_scale;
  logic [7:0]       s1_pass;
  logic             s1_cal;
  logic [31:0]      prod;

  assign frame_end = i_valid && (i_addr >= ADDRW'(MAX_ADDR));

  // Statistics including the current pixel, so frame end captures its own sample.
  always_comb begin
    stat_min = run_min;
    stat_max = run_max;
    if (i_valid) begin
      if (i_addr == '0) begin
        stat_min = i_data;
        stat_max = i_data;
      end else begin
        if (i_data < run_min) stat_min = i_data;
        if (i_data > run_max) stat_max = i_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_min <= '1;
      run_max <= '0;
    end else begin
      run_min <= stat_min;
      run_max <= stat_max;
    end
  end

  // Divider FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Divider FSM: next state; a frame end always (re)starts DIV, even with i_clear
  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      state_nxt = DIV;
    end else if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DIV:     if (iter == 4'd15) state_nxt = LOAD;
        LOAD:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Divider FSM: outputs; a restart or clear in LOAD discards the stale quotient
  always_comb begin
    o_busy  = 1'b0;
    load_en = 1'b0;
    case (state)
      DIV:  o_busy = 1'b1;
      LOAD: begin
        o_busy  = 1'b1;
        load_en = !frame_end && !i_clear;
      end
      default: o_busy = 1'b0;
    endcase
  end

  assign trial = {rem, dvd[15]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_min <= '0;
      div_den <= '0;
      dvd     <= '0;
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
    end else if (frame_end) begin
      div_min <= stat_min;
      div_den <= stat_max - stat_min;
      dvd     <= DIVIDEND;
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
    end else if (state == DIV) begin
      iter <= iter + 4'd1;
      dvd  <= {dvd[14:0], 1'b0};
      if (trial >= {1'b0, div_den}) begin
        rem <= 16'(trial - {1'b0, div_den});
        quo <= {quo[14:0], 1'b1};
      end else begin
        rem <= trial[15:0];
        quo <= {quo[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_min     <= '0;
      act_scale   <= '0;
      o_cal_valid <= 1'b0;
    end else begin
      if (load_en) begin
        act_min   <= div_min;
        act_scale <= (div_den == '0) ? '0 : quo;
      end
      if (i_clear)      o_cal_valid <= 1'b0;
      else if (load_en) o_cal_valid <= 1'b1;
    end
  end

  // Stage 1 snapshots the calibration so both stages of a pixel use the same one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_diff  <= '0;
      s1_scale <= '0;
      s1_pass  <= '0;
      s1_cal   <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      s1_addr  <= i_addr;
      s1_diff  <= (i_data > act_min) ? i_data - act_min : '0;
      s1_scale <= act_scale;
      s1_pass  <= i_data[15:8];
      s1_cal   <= o_cal_valid;
    end
  end

  assign prod = 32'(s1_diff) * 32'(s1_scale);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
    end else begin
      o_wr_valid <= s1_valid;
      o_wr_addr  <= s1_addr;
      if (!s1_cal)           o_wr_data <= s1_pass;
      else if (|prod[31:16]) o_wr_data <= 8'hFF;
      else                   o_wr_data <= prod[15:8];
    end
  end

endmodule

// File: tb/tb_pixel_normalizer.sv
// Self-checking bench: per-cycle comparison against an event-level calibration model,
// plus table vectors and directed multi-cycle sequences.
module tb_pixel_normalizer;

  localparam int MAX_ADDR = 767;
  localparam int ADDRW    = $clog2(MAX_ADDR + 1);

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_valid = 1'b0;
  logic [ADDRW-1:0] i_addr = '0;
  logic [15:0]      i_data = '0;
  logic             o_wr_valid;
  logic [ADDRW-1:0] o_wr_addr;
  logic [7:0]       o_wr_data;
  logic             o_busy;
  logic             o_cal_valid;

  pixel_normalizer #(.MAX_ADDR(MAX_ADDR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid),
    .i_addr(i_addr), .i_data(i_data), .o_wr_valid(o_wr_valid),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy),
    .o_cal_valid(o_cal_valid)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: frame statistics, calibration in effect, and a pending
  // divide that becomes the calibration 17 cycles after its frame end.
  int cyc = 0;
  int m_run_min = 65535, m_run_max = 0;
  bit m_cal = 0;
  int m_act_min = 0, m_act_scale = 0;
  bit m_pend = 0;
  int m_pend_due = 0, m_pend_min = 0, m_pend_max = 0;
  bit pv_v = 0;
  int pv_a = 0, pv_d = 0;

  typedef struct { int data; int exp; } vec_t;
  vec_t cal_vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int norm(input int d);
    int diff;
    longint p;
    diff = (d < m_act_min) ? 0 : d - m_act_min;
    p = (longint'(diff) * longint'(m_act_scale)) >>> 8;
    return (p > 255) ? 255 : int'(p);
  endfunction

  task automatic step(input bit v, input int a, input int d, input bit clr);
    bit fe, cur_v;
    int cur_a, cur_d;
    i_valid = v;
    i_addr  = ADDRW'(a);
    i_data  = 16'(d);
    i_clear = clr;
    @(posedge i_clk);
    cyc++;
    cur_v = v;
    cur_a = a;
    cur_d = m_cal ? norm(d) : (d >> 8);
    fe = v && (a >= MAX_ADDR);
    if (v) begin
      if (a == 0) begin
        m_run_min = d;
        m_run_max = d;
      end else begin
        if (d < m_run_min) m_run_min = d;
        if (d > m_run_max) m_run_max = d;
      end
    end
    if (m_pend && m_pend_due == cyc && !fe && !clr) begin
      m_cal = 1;
      m_act_min = m_pend_min;
      m_act_scale = (m_pend_max == m_pend_min) ? 0 : 65280 / (m_pend_max - m_pend_min);
      m_pend = 0;
    end
    if (clr) begin
      m_cal = 0;
      m_pend = 0;
    end
    if (fe) begin
      m_pend = 1;
      m_pend_due = cyc + 17;
      m_pend_min = m_run_min;
      m_pend_max = m_run_max;
    end
    #1;
    check("wr_valid", o_wr_valid, pv_v);
    if (pv_v) begin
      check("wr_addr", o_wr_addr, pv_a);
      check("wr_data", o_wr_data, pv_d);
    end
    check("busy", o_busy, m_pend);
    check("cal_valid", o_cal_valid, m_cal);
    pv_v = cur_v;
    pv_a = cur_a;
    pv_d = cur_d;
  endtask

  task automatic do_reset();
    i_valid = 0;
    i_clear = 0;
    i_rst = 1;
    #2;
    check("rst_wr_valid", o_wr_valid, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cal_valid", o_cal_valid, 0);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 0;
    m_run_min = 65535;
    m_run_max = 0;
    m_cal = 0;
    m_act_min = 0;
    m_act_scale = 0;
    m_pend = 0;
    pv_v = 0;
  endtask

  task automatic frame(input int lo, input int hi);
    step(1, 0, lo, 0);
    for (int i = 1; i < 4; i++) step(1, i * 100, lo + int'($urandom_range(hi - lo, 0)), 0);
    step(1, MAX_ADDR, hi, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && o_busy; i++) step(0, 0, 0, 0);
    check("idle_timeout", o_busy, 0);
  endtask

  task automatic pix_check(input string name, input int a, input int d, input int exp);
    step(1, a, d, 0);
    step(0, 0, 0, 0);
    check(name, o_wr_data, exp);
    check({name, "_addr"}, o_wr_addr, a);
  endtask

  initial begin
    int cnt;
    cal_vecs[0] = '{1500, 126};
    cal_vecs[1] = '{2000, 253};
    cal_vecs[2] = '{900, 0};
    cal_vecs[3] = '{3000, 255};
    cal_vecs[4] = '{1000, 0};
    cal_vecs[5] = '{1001, 0};

    #1;
    do_reset();
    pix_check("uncal_abcd", 5, 'hABCD, 'hAB);

    frame(1000, 2000);
    cnt = o_busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      if (o_busy) cnt++;
      else break;
    end
    check("busy_len", cnt, 17);
    check("cal_after_load", o_cal_valid, 1);
    foreach (cal_vecs[i]) pix_check("cal_vec", 10 + i, cal_vecs[i].data, cal_vecs[i].exp);

    frame(4000, 4000);
    wait_idle();
    check("flat_cal", o_cal_valid, 1);
    pix_check("flat_hi", 11, 50000, 0);
    pix_check("flat_eq", 12, 4000, 0);

    frame(1000, 2000);
    repeat (5) step(0, 0, 0, 0);
    frame(0, 255);
    wait_idle();
    check("b2b_cal", o_cal_valid, 1);
    pix_check("b2b_100", 7, 100, 100);

    frame(1000, 2000);
    repeat (8) step(0, 0, 0, 0);
    do_reset();
    repeat (30) step(0, 0, 0, 0);
    check("abort_no_load", o_cal_valid, 0);
    pix_check("post_rst_pass", 3, 'hBEEF, 'hBE);

    frame(1000, 2000);
    wait_idle();
    step(0, 0, 0, 1);
    check("clear_cal", o_cal_valid, 0);
    pix_check("clear_pass", 9, 'h1234, 'h12);
    frame(0, 255);
    wait_idle();
    check("recal_cal", o_cal_valid, 1);
    pix_check("recal_100", 2, 100, 100);

    step(1, 0, 500, 0);
    step(1, MAX_ADDR, 755, 1);
    check("clr_fe_cal", o_cal_valid, 0);
    check("clr_fe_busy", o_busy, 1);
    wait_idle();
    check("clr_fe_recal", o_cal_valid, 1);
    pix_check("clr_fe_755", 4, 755, 255);

    for (int n = 0; n < 3000; n++) begin
      int r, a, d;
      bit v, c;
      r = int'($urandom_range(63, 0));
      if (r == 0)      a = 0;
      else if (r == 1) a = MAX_ADDR + int'($urandom_range(1023 - MAX_ADDR, 0));
      else             a = int'($urandom_range(MAX_ADDR - 1, 1));
      d = ($urandom_range(1, 0) == 1) ? int'($urandom_range(65535, 0))
                                      : 1000 + int'($urandom_range(2000, 0));
      v = ($urandom_range(7, 0) != 0);
      c = ($urandom_range(99, 0) == 0);
      step(v, a, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
